// File: rtl/path_streamer.sv
// Snapshots the Dijkstra path on a rising success and streams it as one coordinate per valid/ready beat.
// The first beat appears one cycle after capture. out_valid is held, with stable data, until a handshake occurs.
module path_streamer #(
  parameter int MAX_PATH = 100,
  parameter int COORD_W  = 16,
  parameter bit REVERSE  = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            success,
  input  logic [15:0]                     path_len,
  input  logic [2*COORD_W*MAX_PATH-1:0]   path_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [COORD_W-1:0]              out_x,
  output logic [COORD_W-1:0]              out_y,
  output logic                            out_last,
  output logic [15:0]                     out_seq,
  output logic                            busy,
  output logic                            done,
  output logic                            err_empty,
  output logic                            truncated
);
  localparam int EW = 2 * COORD_W;
  localparam int PW = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  state_t                          state;
  logic                            success_q;
  logic                            vld;
  logic [MAX_PATH-1:0][EW-1:0]     snap;
  logic [PW-1:0]                   ptr;
  logic [15:0]                     seq;
  logic [15:0]                     len_q;
  logic [15:0]                     len_clamp;
  logic                            start_ev;
  logic                            capture;
  logic                            is_last;
  logic [EW-1:0]                   entry;

  assign start_ev  = success & ~success_q;
  assign capture   = (state == IDLE) && start_ev && (path_len != 16'd0);
  assign len_clamp = (path_len > 16'(MAX_PATH)) ? 16'(MAX_PATH) : path_len;
  assign is_last   = (seq == len_q - 16'd1);
  assign entry     = snap[ptr];

  // Snapshot is data-only; its contents are irrelevant until the next capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      snap <= path_flat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      success_q <= 1'b0;
      vld       <= 1'b0;
      done      <= 1'b0;
      err_empty <= 1'b0;
      truncated <= 1'b0;
      ptr       <= '0;
      seq       <= 16'd0;
      len_q     <= 16'd0;
    end else begin
      success_q <= success;
      done      <= 1'b0;
      err_empty <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev) begin
            if (path_len == 16'd0) begin
              err_empty <= 1'b1;
            end else begin
              len_q     <= len_clamp;
              truncated <= (path_len > 16'(MAX_PATH));
              ptr       <= REVERSE ? PW'(len_clamp - 16'd1) : '0;
              seq       <= 16'd0;
              vld       <= 1'b1;
              state     <= STREAM;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            // Counters stop at the last beat so they never step past either end.
            if (is_last) begin
              vld   <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              seq <= seq + 16'd1;
              ptr <= REVERSE ? ptr - PW'(1) : ptr + PW'(1);
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = vld;
  assign busy      = vld;
  assign out_x     = vld ? entry[EW-1:COORD_W] : '0;
  assign out_y     = vld ? entry[COORD_W-1:0]  : '0;
  assign out_seq   = vld ? seq : 16'd0;
  assign out_last  = vld & is_last;
endmodule

// File: tb/tb_path_streamer.sv
// Directed bench for path_streamer: reverse and forward instances share one stimulus set.
module tb_path_streamer;
  localparam int MP = 100;
  localparam int CW = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    success;
  logic [15:0]             path_len;
  logic [2*CW*MP-1:0]      path_flat;
  logic                    out_ready;

  logic                    r_valid, r_last, r_busy, r_done, r_err, r_trunc;
  logic [CW-1:0]           r_x, r_y;
  logic [15:0]             r_seq;
  logic                    f_valid, f_last, f_busy, f_done, f_err, f_trunc;
  logic [CW-1:0]           f_x, f_y;
  logic [15:0]             f_seq;

  int errors = 0;
  int checks = 0;

  logic [15:0] ex [3];
  logic [15:0] ey [3];

  always #5 clk = ~clk;

  path_streamer #(.MAX_PATH(MP), .COORD_W(CW), .REVERSE(1'b1)) dut (
    .clk(clk), .reset(reset), .success(success), .path_len(path_len), .path_flat(path_flat),
    .out_valid(r_valid), .out_ready(out_ready), .out_x(r_x), .out_y(r_y), .out_last(r_last),
    .out_seq(r_seq), .busy(r_busy), .done(r_done), .err_empty(r_err), .truncated(r_trunc)
  );

  path_streamer #(.MAX_PATH(MP), .COORD_W(CW), .REVERSE(1'b0)) dut_fwd (
    .clk(clk), .reset(reset), .success(success), .path_len(path_len), .path_flat(path_flat),
    .out_valid(f_valid), .out_ready(out_ready), .out_x(f_x), .out_y(f_y), .out_last(f_last),
    .out_seq(f_seq), .busy(f_busy), .done(f_done), .err_empty(f_err), .truncated(f_trunc)
  );

  task automatic load_small();
    path_flat = '0;
    for (int k = 0; k < 3; k++) path_flat[k*32 +: 32] = {ex[k], ey[k]};
    path_len = 16'd3;
  endtask

  task automatic load_ramp(input int n);
    path_flat = '0;
    for (int k = 0; k < MP; k++) path_flat[k*32 +: 32] = {16'(k + 16'h100), 16'(k + 16'h200)};
    path_len = 16'(n);
  endtask

  task automatic test_reset();
    reset = 1'b1; success = 1'b0; out_ready = 1'b0; path_len = 16'd0; path_flat = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r_valid, r_x, r_y, r_last, r_seq, r_busy, r_done, r_err, r_trunc} !== '0)
      begin errors++; $display("FAIL reset_rev outputs=%h required 0", {r_valid, r_x, r_y, r_last, r_seq, r_busy, r_done, r_err, r_trunc}); end
    checks++;
    if ({f_valid, f_x, f_y, f_last, f_seq, f_busy, f_done, f_err, f_trunc} !== '0)
      begin errors++; $display("FAIL reset_fwd outputs=%h required 0", {f_valid, f_x, f_y, f_last, f_seq, f_busy, f_done, f_err, f_trunc}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Reverse and forward order, first-beat latency, out_last position and done timing.
  task automatic test_stream();
    load_small();
    out_ready = 1'b1;
    success = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({r_valid, r_busy, r_x, r_y, r_seq, r_last} !== {1'b1, 1'b1, ex[2-i], ey[2-i], 16'(i), (i == 2)})
        begin errors++; $display("FAIL rev_beat%0d got v=%b x=%h y=%h seq=%0d last=%b required x=%h y=%h seq=%0d", i, r_valid, r_x, r_y, r_seq, r_last, ex[2-i], ey[2-i], i); end
      checks++;
      if ({f_valid, f_x, f_y, f_seq, f_last} !== {1'b1, ex[i], ey[i], 16'(i), (i == 2)})
        begin errors++; $display("FAIL fwd_beat%0d got v=%b x=%h y=%h seq=%0d last=%b required x=%h y=%h seq=%0d", i, f_valid, f_x, f_y, f_seq, f_last, ex[i], ey[i], i); end
    end
    @(negedge clk);
    checks++;
    if ({r_done, r_valid, r_busy, f_done, f_valid} !== 5'b10010)
      begin errors++; $display("FAIL done_pulse got rd=%b rv=%b rb=%b fd=%b fv=%b required 10010", r_done, r_valid, r_busy, f_done, f_valid); end
    @(negedge clk);
    checks++;
    if ({r_done, f_done} !== 2'b00)
      begin errors++; $display("FAIL done_width got %b%b required 00", r_done, f_done); end
    success = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int idx;
    int hs;
    pat = 6'b110100; // applied LSB first: 0,0,1,0,1,1
    idx = 0; hs = 0;
    load_small();
    out_ready = 1'b0;
    success = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (idx > 2 || {r_valid, r_x, r_y, r_seq} !== {1'b1, ex[2-idx], ey[2-idx], 16'(idx)})
        begin errors++; $display("FAIL bp_cycle%0d got v=%b x=%h y=%h seq=%0d required beat %0d", c, r_valid, r_x, r_y, r_seq, idx); end
      out_ready = pat[c];
      if (r_valid && out_ready) begin idx++; hs++; end
      @(negedge clk);
    end
    checks++;
    if (hs != 3 || r_done !== 1'b1 || r_valid !== 1'b0)
      begin errors++; $display("FAIL bp_handshakes got hs=%0d done=%b valid=%b required 3/1/0", hs, r_done, r_valid); end
    success = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty_retrigger();
    int errs_seen;
    int vld_seen;
    errs_seen = 0; vld_seen = 0;
    path_len = 16'd0;
    success = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (r_err) errs_seen++;
      if (r_valid) vld_seen++;
    end
    checks++;
    if (errs_seen != 1 || vld_seen != 0)
      begin errors++; $display("FAIL empty got err_pulses=%0d valid_cycles=%0d required 1/0", errs_seen, vld_seen); end
    success = 1'b0;
    @(negedge clk);
    load_small();
    out_ready = 1'b1;
    success = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (r_done !== 1'b1)
      begin errors++; $display("FAIL retrig_done got %b required 1", r_done); end
    vld_seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (r_valid || r_err) vld_seen++;
    end
    checks++;
    if (vld_seen != 0)
      begin errors++; $display("FAIL retrigger got active_cycles=%0d required 0", vld_seen); end
    success = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_truncation();
    int beats;
    int bad;
    int last_seq;
    beats = 0; bad = 0; last_seq = -1;
    load_ramp(120);
    out_ready = 1'b1;
    success = 1'b1;
    @(negedge clk);
    checks++;
    if (r_trunc !== 1'b1 || f_trunc !== 1'b1)
      begin errors++; $display("FAIL trunc_flag got %b%b required 11", r_trunc, f_trunc); end
    for (int c = 0; c < 110; c++) begin
      if (r_valid) begin
        if ({r_x, r_y, r_seq} !== {16'(99 - beats + 16'h100), 16'(99 - beats + 16'h200), 16'(beats)}) bad++;
        if (r_last) last_seq = int'(r_seq);
        beats++;
      end
      @(negedge clk);
    end
    checks++;
    if (beats != 100 || bad != 0 || last_seq != 99)
      begin errors++; $display("FAIL trunc_stream got beats=%0d bad=%0d last_seq=%0d required 100/0/99", beats, bad, last_seq); end
    success = 1'b0;
    @(negedge clk);
    load_ramp(5);
    success = 1'b1;
    @(negedge clk);
    checks++;
    if (r_trunc !== 1'b0 || r_valid !== 1'b1)
      begin errors++; $display("FAIL trunc_clear got trunc=%b valid=%b required 0/1", r_trunc, r_valid); end
    repeat (7) @(negedge clk);
    success = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    int vlds;
    dones = 0; vlds = 0;
    load_ramp(10);
    out_ready = 1'b1;
    success = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({r_valid, r_seq, r_x} !== {1'b1, 16'd1, 16'h108})
      begin errors++; $display("FAIL mid_beat2 got v=%b seq=%0d x=%h required 1/1/0108", r_valid, r_seq, r_x); end
    reset = 1'b1;
    success = 1'b0;
    @(negedge clk);
    checks++;
    if (r_valid !== 1'b0 || r_done !== 1'b0)
      begin errors++; $display("FAIL mid_reset got valid=%b done=%b required 0/0", r_valid, r_done); end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (r_done) dones++;
      if (r_valid) vlds++;
    end
    checks++;
    if (dones != 0 || vlds != 0)
      begin errors++; $display("FAIL mid_quiet got done=%0d valid=%0d required 0/0", dones, vlds); end
    success = 1'b1;
    @(negedge clk);
    checks++;
    if ({r_valid, r_seq, r_x, r_y} !== {1'b1, 16'd0, 16'h109, 16'h209})
      begin errors++; $display("FAIL mid_restart got v=%b seq=%0d x=%h y=%h required 1/0/0109/0209", r_valid, r_seq, r_x, r_y); end
    repeat (10) @(negedge clk);
    checks++;
    if (r_done !== 1'b1)
      begin errors++; $display("FAIL mid_restart_done got %b required 1", r_done); end
    success = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    ex[0] = 16'h0015; ey[0] = 16'h0012;
    ex[1] = 16'h0100; ey[1] = 16'h0080;
    ex[2] = 16'h0225; ey[2] = 16'h01bd;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty_retrigger();
    test_truncation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
